// File: rtl/axi_pkg.sv
// Shared AXI4 burst/response encodings and FSM state types for the burst memory responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

endpackage

// File: rtl/axi_burst_addr_chk.sv
// Combinational burst address checker: flags size/burst/range errors for a new request and
// produces the next beat address and word index for the burst in flight.
module axi_burst_addr_chk
    import axi_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       MEM_BYTES = 8192,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       IDX_W     = 10
) (
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic [1:0]        cur_burst,
    output logic              err,
    output logic [ADDR_W-1:0] next_addr,
    output logic [IDX_W-1:0]  word_idx
);

    localparam int unsigned BEAT_BYTES = DATA_W / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned EXT_W      = ADDR_W + 17;

    logic [ADDR_W:0]   diff;
    logic [EXT_W-1:0]  end_off;
    logic [ADDR_W-1:0] cur_off;

    always_comb begin
        // The extra top bit of diff is the borrow, i.e. start below BASE_ADDR.
        diff    = {1'b0, start_addr} - {1'b0, BASE_ADDR};
        end_off = EXT_W'(diff[ADDR_W-1:0]) + ((EXT_W'(len) + EXT_W'(1)) << BEAT_SHIFT);
        err     = (size != 3'(BEAT_SHIFT))
                  || !((burst == BURST_FIXED) || (burst == BURST_INCR))
                  || diff[ADDR_W]
                  || (end_off > EXT_W'(MEM_BYTES));

        next_addr = (cur_burst == BURST_INCR) ? cur_addr + ADDR_W'(BEAT_BYTES) : cur_addr;
        cur_off   = cur_addr - BASE_ADDR;
        word_idx  = IDX_W'(cur_off >> BEAT_SHIFT);
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 responder memory: independent write and read burst FSMs (INCR/FIXED, full-width beats)
// over a byte-strobed word array, with SLVERR for bad size, burst type or range.
module axi_burst_mem_slave
    import axi_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       MEM_BYTES = 8192,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_W-1:0]     S_AWID,
    input  logic [ADDR_W-1:0]   S_AWADDR,
    input  logic [7:0]          S_AWLEN,
    input  logic [2:0]          S_AWSIZE,
    input  logic [1:0]          S_AWBURST,
    input  logic                S_AWVALID,
    output logic                S_AWREADY,
    input  logic [DATA_W-1:0]   S_WDATA,
    input  logic [DATA_W/8-1:0] S_WSTRB,
    input  logic                S_WLAST,
    input  logic                S_WVALID,
    output logic                S_WREADY,
    output logic [ID_W-1:0]     S_BID,
    output logic [1:0]          S_BRESP,
    output logic                S_BVALID,
    input  logic                S_BREADY,
    input  logic [ID_W-1:0]     S_ARID,
    input  logic [ADDR_W-1:0]   S_ARADDR,
    input  logic [7:0]          S_ARLEN,
    input  logic [2:0]          S_ARSIZE,
    input  logic [1:0]          S_ARBURST,
    input  logic                S_ARVALID,
    output logic                S_ARREADY,
    output logic [ID_W-1:0]     S_RID,
    output logic [DATA_W-1:0]   S_RDATA,
    output logic [1:0]          S_RRESP,
    output logic                S_RLAST,
    output logic                S_RVALID,
    input  logic                S_RREADY
);

    localparam int unsigned BEAT_BYTES = DATA_W / 8;
    localparam int unsigned WORDS      = MEM_BYTES / BEAT_BYTES;
    localparam int unsigned IDX_W      = $clog2(WORDS);

    logic [DATA_W-1:0] mem [WORDS] = '{default: '0};

    w_state_e          w_state;
    logic [ID_W-1:0]   w_id_q;
    logic [ADDR_W-1:0] w_addr_q, w_next_addr;
    logic [7:0]        w_cnt_q;
    logic [1:0]        w_burst_q;
    logic              w_err_q, aw_err, w_hs, w_last_bad, w_we;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_bitmask;

    r_state_e          r_state;
    logic [ID_W-1:0]   r_id_q;
    logic [ADDR_W-1:0] r_addr_q, r_next_addr;
    logic [7:0]        r_cnt_q;
    logic [1:0]        r_burst_q;
    logic              r_err_q, ar_err;
    logic [IDX_W-1:0]  r_idx;

    axi_burst_addr_chk #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_aw_chk (
        .start_addr(S_AWADDR), .len(S_AWLEN), .size(S_AWSIZE), .burst(S_AWBURST),
        .cur_addr(w_addr_q), .cur_burst(w_burst_q),
        .err(aw_err), .next_addr(w_next_addr), .word_idx(w_idx)
    );

    axi_burst_addr_chk #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_ar_chk (
        .start_addr(S_ARADDR), .len(S_ARLEN), .size(S_ARSIZE), .burst(S_ARBURST),
        .cur_addr(r_addr_q), .cur_burst(r_burst_q),
        .err(ar_err), .next_addr(r_next_addr), .word_idx(r_idx)
    );

    for (genvar b = 0; b < BEAT_BYTES; b++) begin : g_strb
        assign w_bitmask[8*b +: 8] = {8{S_WSTRB[b]}};
    end

    assign w_hs       = S_WVALID && S_WREADY;
    assign w_last_bad = S_WLAST != (w_cnt_q == 8'd0);
    assign w_we       = w_hs && !w_err_q && !w_last_bad;

    // No reset: contents survive ARESET.
    always_ff @(posedge ACLK) begin
        if (w_we) begin
            mem[w_idx] <= (mem[w_idx] & ~w_bitmask) | (S_WDATA & w_bitmask);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state   <= W_IDLE;
            S_AWREADY <= 1'b1;
            S_WREADY  <= 1'b0;
            S_BVALID  <= 1'b0;
            S_BID     <= '0;
            S_BRESP   <= RESP_OKAY;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= BURST_FIXED;
            w_err_q   <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: if (S_AWVALID && S_AWREADY) begin
                    w_id_q    <= S_AWID;
                    w_addr_q  <= S_AWADDR;
                    w_cnt_q   <= S_AWLEN;
                    w_burst_q <= S_AWBURST;
                    w_err_q   <= aw_err;
                    S_AWREADY <= 1'b0;
                    S_WREADY  <= 1'b1;
                    w_state   <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_addr_q <= w_next_addr;
                    if (w_cnt_q == 8'd0) begin
                        S_WREADY <= 1'b0;
                        S_BVALID <= 1'b1;
                        S_BID    <= w_id_q;
                        S_BRESP  <= (w_err_q || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                        w_state  <= W_RESP;
                    end else begin
                        w_cnt_q <= w_cnt_q - 8'd1;
                        if (w_last_bad) w_err_q <= 1'b1;
                    end
                end
                W_RESP: if (S_BREADY) begin
                    S_BVALID  <= 1'b0;
                    S_AWREADY <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= R_IDLE;
            S_ARREADY <= 1'b1;
            S_RVALID  <= 1'b0;
            S_RLAST   <= 1'b0;
            S_RID     <= '0;
            S_RRESP   <= RESP_OKAY;
            S_RDATA   <= '0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= BURST_FIXED;
            r_err_q   <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: if (S_ARVALID && S_ARREADY) begin
                    r_id_q    <= S_ARID;
                    r_addr_q  <= S_ARADDR;
                    r_cnt_q   <= S_ARLEN;
                    r_burst_q <= S_ARBURST;
                    r_err_q   <= ar_err;
                    S_ARREADY <= 1'b0;
                    r_state   <= R_DATA;
                end
                // A beat is loaded when the output slot is empty or being drained this edge.
                R_DATA: if (!S_RVALID || S_RREADY) begin
                    if (S_RVALID && S_RLAST) begin
                        S_RVALID  <= 1'b0;
                        S_RLAST   <= 1'b0;
                        S_ARREADY <= 1'b1;
                        r_state   <= R_IDLE;
                    end else begin
                        S_RVALID <= 1'b1;
                        S_RID    <= r_id_q;
                        S_RRESP  <= r_err_q ? RESP_SLVERR : RESP_OKAY;
                        S_RDATA  <= r_err_q ? '0 : mem[r_idx];
                        S_RLAST  <= (r_cnt_q == 8'd0);
                        r_cnt_q  <= r_cnt_q - 8'd1;
                        r_addr_q <= r_next_addr;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
